// File: rtl/arbitro_raiz.sv
// arbitro_raiz: round-robin front end that shares one iterative square-root
// core among N_SOL requesters. One operation is outstanding at a time:
// grant (LIBRE) -> start pulse (LANZAR) -> wait for done (ESPERA) -> respond (ENTREGA).
// Optional feature: define ARBITRO_RAIZ_TIMEOUT_EN to abort an operation whose
// core does not finish within LIMITE ESPERA cycles (response flagged with resp_error).
module arbitro_raiz #(
  parameter int N_SOL  = 4,
  parameter int ANCHO  = 16,
  parameter int ID_W   = $clog2(N_SOL),
  parameter int LIMITE = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SOL-1:0]       sol_valido,
  input  logic [N_SOL*ANCHO-1:0] sol_radicando,
  output logic [N_SOL-1:0]       sol_listo,
  output logic                   resp_valido,
  output logic [ID_W-1:0]        resp_id,
  output logic [ANCHO-1:0]       resp_raiz,
  output logic                   resp_error,
  output logic                   ocupado,
  output logic                   raiz_iniciar,
  output logic [ANCHO-1:0]       raiz_radicando,
  input  logic [ANCHO-1:0]       raiz_res_in,
  input  logic                   raiz_terminado
);

  // Reject configurations the arbiter is not built for.
  if (N_SOL < 2 || N_SOL > 8 || LIMITE < 1 || ID_W < $clog2(N_SOL)) begin : g_param_invalido
    $error("arbitro_raiz: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    LIBRE   = 2'd0,
    LANZAR  = 2'd1,
    ESPERA  = 2'd2,
    ENTREGA = 2'd3
  } estado_t;

  estado_t           estado_q, estado_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ANCHO-1:0]  op_q, op_d;
  logic [ID_W-1:0]   resp_id_q, resp_id_d;
  logic [ANCHO-1:0]  resp_raiz_q, resp_raiz_d;
  logic              resp_valido_q, resp_valido_d;
  logic              iniciar_q, iniciar_d;
  logic              ocupado_q, ocupado_d;

  logic              hay_s;
  logic [ID_W-1:0]   ganador_s;
  logic [ID_W:0]     suma_s;
  logic [ID_W:0]     idx_s;
  logic [ANCHO-1:0]  op_sel_s;

`ifdef ARBITRO_RAIZ_TIMEOUT_EN
  localparam int CNT_W = $clog2(LIMITE + 1);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              resp_error_q, resp_error_d;
`endif

  // Round-robin search: first valid requester after the last winner, wrapping.
  always_comb begin
    hay_s     = 1'b0;
    ganador_s = '0;
    suma_s    = '0;
    idx_s     = '0;
    for (int k = 1; k <= N_SOL; k++) begin
      suma_s    = {1'b0, ptr_q} + (ID_W+1)'(k);
      idx_s     = (suma_s >= (ID_W+1)'(N_SOL)) ? (suma_s - (ID_W+1)'(N_SOL)) : suma_s;
      ganador_s = (!hay_s && sol_valido[idx_s[ID_W-1:0]]) ? idx_s[ID_W-1:0] : ganador_s;
      hay_s     = hay_s | sol_valido[idx_s[ID_W-1:0]];
    end
  end

  // Operand of the current winner.
  always_comb begin
    op_sel_s = '0;
    for (int i = 0; i < N_SOL; i++) begin
      op_sel_s = (ganador_s == ID_W'(i)) ? sol_radicando[i*ANCHO +: ANCHO] : op_sel_s;
    end
  end

  // Accept is combinational and only offered while idle.
  always_comb begin
    sol_listo = (estado_q == LIBRE && hay_s) ? (N_SOL'(1'b1) << ganador_s) : '0;
  end

  // Next-state and registered-output logic.
  always_comb begin
    estado_d      = estado_q;
    ptr_d         = ptr_q;
    id_d          = id_q;
    op_d          = op_q;
    resp_id_d     = resp_id_q;
    resp_raiz_d   = resp_raiz_q;
    resp_valido_d = 1'b0;
    iniciar_d     = 1'b0;
`ifdef ARBITRO_RAIZ_TIMEOUT_EN
    cnt_d         = cnt_q;
    resp_error_d  = 1'b0;
`endif
    case (estado_q)
      LIBRE: begin
        if (hay_s) begin
          estado_d  = LANZAR;
          op_d      = op_sel_s;
          id_d      = ganador_s;
          ptr_d     = ganador_s;
          iniciar_d = 1'b1;
        end else begin
          estado_d  = LIBRE;
        end
      end
      LANZAR: begin
        // The done flag may still be high from the previous operation; ignore it here.
        estado_d = ESPERA;
`ifdef ARBITRO_RAIZ_TIMEOUT_EN
        cnt_d    = '0;
`endif
      end
      ESPERA: begin
        if (raiz_terminado) begin
          estado_d      = ENTREGA;
          resp_raiz_d   = raiz_res_in;
          resp_id_d     = id_q;
          resp_valido_d = 1'b1;
        end
`ifdef ARBITRO_RAIZ_TIMEOUT_EN
        else if (cnt_q == CNT_W'(LIMITE - 1)) begin
          estado_d      = ENTREGA;
          resp_raiz_d   = '0;
          resp_id_d     = id_q;
          resp_valido_d = 1'b1;
          resp_error_d  = 1'b1;
        end else begin
          estado_d      = ESPERA;
          cnt_d         = cnt_q + CNT_W'(1);
        end
`else
        else begin
          estado_d      = ESPERA;
        end
`endif
      end
      ENTREGA: begin
        estado_d = LIBRE;
      end
      default: begin
        estado_d = LIBRE;
      end
    endcase
    ocupado_d = (estado_d != LIBRE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q      <= LIBRE;
      ptr_q         <= ID_W'(N_SOL - 1);
      id_q          <= '0;
      op_q          <= '0;
      resp_id_q     <= '0;
      resp_raiz_q   <= '0;
      resp_valido_q <= 1'b0;
      iniciar_q     <= 1'b0;
      ocupado_q     <= 1'b0;
`ifdef ARBITRO_RAIZ_TIMEOUT_EN
      cnt_q         <= '0;
      resp_error_q  <= 1'b0;
`endif
    end else begin
      estado_q      <= estado_d;
      ptr_q         <= ptr_d;
      id_q          <= id_d;
      op_q          <= op_d;
      resp_id_q     <= resp_id_d;
      resp_raiz_q   <= resp_raiz_d;
      resp_valido_q <= resp_valido_d;
      iniciar_q     <= iniciar_d;
      ocupado_q     <= ocupado_d;
`ifdef ARBITRO_RAIZ_TIMEOUT_EN
      cnt_q         <= cnt_d;
      resp_error_q  <= resp_error_d;
`endif
    end
  end

  assign resp_valido    = resp_valido_q;
  assign resp_id        = resp_id_q;
  assign resp_raiz      = resp_raiz_q;
  assign ocupado        = ocupado_q;
  assign raiz_iniciar   = iniciar_q;
  assign raiz_radicando = op_q;
`ifdef ARBITRO_RAIZ_TIMEOUT_EN
  assign resp_error     = resp_error_q;
`else
  assign resp_error     = 1'b0;
`endif

endmodule

// File: tb/tb_arbitro_raiz.sv
// Self-checking bench for arbitro_raiz: table of single transactions, directed
// multi-cycle sequences, and a randomized run against a round-robin reference
// model. Includes a behavioural square-root core with programmable latency.
module tb_arbitro_raiz;
  localparam int N = 4;
  localparam int W = 16;
  localparam int IW = 2;
  localparam int LIM = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   sol_valido;
  logic [N*W-1:0] sol_radicando;
  logic [N-1:0]   sol_listo;
  logic           resp_valido;
  logic [IW-1:0]  resp_id;
  logic [W-1:0]   resp_raiz;
  logic           resp_error;
  logic           ocupado;
  logic           raiz_iniciar;
  logic [W-1:0]   raiz_radicando;
  logic [W-1:0]   raiz_res_in;
  logic           raiz_terminado;

  int checks = 0;
  int errors = 0;

  // core model controls
  int         core_lat = 0;
  bit         core_mudo = 1'b0;
  logic       core_busy;
  int         core_cnt;
  logic [W-1:0] core_op;

  typedef struct {
    int id;
    int op;
    int raiz;
    int lat;
  } vec_t;
  vec_t tabla [8];

  always #5 clk = ~clk;

  arbitro_raiz #(.N_SOL(N), .ANCHO(W), .ID_W(IW), .LIMITE(LIM)) dut (
    .clk(clk), .rst(rst),
    .sol_valido(sol_valido), .sol_radicando(sol_radicando), .sol_listo(sol_listo),
    .resp_valido(resp_valido), .resp_id(resp_id), .resp_raiz(resp_raiz),
    .resp_error(resp_error), .ocupado(ocupado),
    .raiz_iniciar(raiz_iniciar), .raiz_radicando(raiz_radicando),
    .raiz_res_in(raiz_res_in), .raiz_terminado(raiz_terminado)
  );

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Behavioural iterative root core: done stays high until the next start.
  always @(posedge clk) begin
    if (rst) begin
      core_busy      <= 1'b0;
      core_cnt       <= 0;
      core_op        <= '0;
      raiz_terminado <= 1'b0;
      raiz_res_in    <= '0;
    end else if (raiz_iniciar) begin
      core_busy      <= 1'b1;
      core_cnt       <= core_lat;
      core_op        <= raiz_radicando;
      raiz_terminado <= 1'b0;
    end else if (core_busy) begin
      if (core_cnt == 0) begin
        core_busy      <= 1'b0;
        raiz_terminado <= !core_mudo;
        raiz_res_in    <= core_mudo ? 16'hBEEF : W'(isqrt(int'(core_op)));
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  task automatic chk(input string nombre, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nombre, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sol_valido = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) for a grant; returns the granted index or -1.
  task automatic wait_grant(output int id);
    id = -1;
    for (int n = 0; n < 100; n++) begin
      #1;
      if (sol_listo != '0) begin
        chk("listo_onehot", 32'($countones(sol_listo)), 32'd1);
        for (int i = 0; i < N; i++) if (sol_listo[i]) id = i;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (id < 0) begin
      errors++;
      $display("FAIL grant_timeout: got no grant expected one within 100 cycles");
    end
  endtask

  // One complete transaction from grant to response; ends at a LIBRE negedge.
  task automatic txn(input int exp_id, input int exp_root, input int lat, input bit keep, input bit exp_err);
    int id;
    int cyc;
    int nini;
    logic [W-1:0] op;
    core_lat = lat;
    wait_grant(id);
    if (id < 0) return;
    chk("grant_id", 32'(id), 32'(exp_id));
    op = sol_radicando[id*W +: W];
    cyc = 0;
    nini = 0;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        if (!keep) sol_valido[id] = 1'b0;
        chk("ocupado_lanzar", 32'(ocupado), 32'd1);
      end
      if (raiz_iniciar) begin
        nini++;
        chk("radicando", 32'(raiz_radicando), 32'(op));
      end
      if (resp_valido) break;
    end
    chk("resp_seen", 32'(resp_valido), 32'd1);
    chk("resp_id", 32'(resp_id), 32'(exp_id));
    chk("resp_raiz", 32'(resp_raiz), 32'(exp_root));
    chk("resp_error", 32'(resp_error), 32'(exp_err));
    chk("iniciar_pulsos", 32'(nini), 32'd1);
    if (exp_err) chk("latencia_timeout", 32'(cyc - 1), 32'(1 + LIM));
    else         chk("latencia", 32'(cyc - 1), 32'(lat + 3));
    @(negedge clk);
    chk("resp_pulso", 32'(resp_valido), 32'd0);
    chk("error_pulso", 32'(resp_error), 32'd0);
    chk("ocupado_libre", 32'(ocupado), 32'd0);
    chk("resp_id_hold", 32'(resp_id), 32'(exp_id));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int rsp;
    bit pend [N];
    int m_ptr;
    bit m_busy;
    int m_id;
    int m_root;
    int exp_w;
    logic [N-1:0] exp_listo;

    rst = 1'b1;
    sol_valido = '0;
    sol_radicando = '0;
    tabla[0] = '{0, 144, 12, 2};
    tabla[1] = '{2, 0, 0, 0};
    tabla[2] = '{2, 1, 1, 3};
    tabla[3] = '{2, 65535, 255, 1};
    tabla[4] = '{1, 400, 20, 4};
    tabla[5] = '{3, 65534, 255, 0};
    tabla[6] = '{0, 2, 1, 5};
    tabla[7] = '{3, 15, 3, 2};

    // reset state
    do_reset();
    #1;
    chk("rst_listo", 32'(sol_listo), 32'd0);
    chk("rst_resp_valido", 32'(resp_valido), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_resp_raiz", 32'(resp_raiz), 32'd0);
    chk("rst_resp_error", 32'(resp_error), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_iniciar", 32'(raiz_iniciar), 32'd0);
    chk("rst_radicando", 32'(raiz_radicando), 32'd0);

    // table of single transactions
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      sol_radicando[tabla[t].id*W +: W] = W'(tabla[t].op);
      sol_valido[tabla[t].id] = 1'b1;
      txn(tabla[t].id, tabla[t].raiz, tabla[t].lat, 1'b0, 1'b0);
    end

    // simultaneous requests from reset: order 0,1,2,3
    do_reset();
    sol_radicando = {16'd49, 16'd36, 16'd25, 16'd16};
    sol_valido = 4'b1111;
    for (int t = 0; t < 4; t++) txn(t, t + 4, t, 1'b0, 1'b0);

    // fairness: 1 and 3 held valid continuously
    sol_radicando[1*W +: W] = 16'd81;
    sol_radicando[3*W +: W] = 16'd100;
    sol_valido = 4'b1010;
    for (int t = 0; t < 6; t++) begin
      if (t % 2 == 0) txn(1, 9, 1, 1'b1, 1'b0);
      else            txn(3, 10, 2, 1'b1, 1'b0);
    end
    sol_valido = '0;

    // reset in the middle of ESPERA
    @(negedge clk);
    core_lat = 20;
    sol_radicando[0 +: W] = 16'd400;
    sol_valido[0] = 1'b1;
    wait_grant(rsp);
    @(negedge clk);
    sol_valido[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ocupado", 32'(ocupado), 32'd0);
    chk("rst_mid_resp_valido", 32'(resp_valido), 32'd0);
    chk("rst_mid_radicando", 32'(raiz_radicando), 32'd0);
    rsp = 0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valido) rsp++;
    end
    chk("rst_mid_sin_resp", 32'(rsp), 32'd0);
    sol_valido[0] = 1'b1;
    txn(0, 20, 2, 1'b0, 1'b0);

`ifdef ARBITRO_RAIZ_TIMEOUT_EN
    // watchdog abort; the next requester is served afterwards
    core_mudo = 1'b1;
    sol_radicando[2*W +: W] = 16'd49;
    sol_radicando[3*W +: W] = 16'd64;
    sol_valido = 4'b1100;
    txn(2, 0, 0, 1'b0, 1'b1);
    core_mudo = 1'b0;
    txn(3, 8, 1, 1'b0, 1'b0);
`endif

    // randomized run against the round-robin reference model
    do_reset();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    m_ptr = N - 1;
    m_busy = 1'b0;
    m_id = 0;
    m_root = 0;
    for (int c = 0; c < 4400; c++) begin
      @(negedge clk);
      if (c == 4000) for (int i = 0; i < N; i++) pend[i] = 1'b0;
      if (c >= 4000 && !m_busy) break;
      core_lat = $urandom_range(0, 4);
      if (c < 4000) begin
        for (int i = 0; i < N; i++) begin
          if (!pend[i]) begin
            if ($urandom_range(0, 2) == 0) begin
              pend[i] = 1'b1;
              sol_radicando[i*W +: W] = W'($urandom_range(0, 65535));
            end
          end else if ($urandom_range(0, 24) == 0) begin
            pend[i] = 1'b0;
          end
        end
      end
      for (int i = 0; i < N; i++) sol_valido[i] = pend[i];
      #1;
      exp_w = -1;
      if (!m_busy) begin
        for (int k = 1; k <= N; k++) begin
          if (exp_w < 0 && pend[(m_ptr + k) % N]) exp_w = (m_ptr + k) % N;
        end
      end
      exp_listo = (exp_w >= 0) ? N'(1 << exp_w) : '0;
      chk("rnd_listo", 32'(sol_listo), 32'(exp_listo));
      if (resp_valido) begin
        chk("rnd_resp_en_curso", 32'(m_busy), 32'd1);
        chk("rnd_resp_id", 32'(resp_id), 32'(m_id));
        chk("rnd_resp_raiz", 32'(resp_raiz), 32'(m_root));
        m_busy = 1'b0;
      end
      if (exp_w >= 0) begin
        m_busy = 1'b1;
        m_ptr = exp_w;
        m_id = exp_w;
        m_root = isqrt(int'(sol_radicando[exp_w*W +: W]));
        pend[exp_w] = 1'b0;
      end
    end
    chk("rnd_drenado", 32'(m_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/arbitro_raiz.md
Name: arbitro_raiz

Overview:
- Shares one iterative square-root core among N_SOL requesters (keypad path, display formatter, test port, ...).
- Arbitrates requests round-robin and launches the core with a one-cycle `iniciar`.
- Waits for the core's `terminado`, then returns the 16-bit root to the winner, tagged with its requester ID.
- Sits between the calculator operation decoder and the root core.

Parameters:
- N_SOL, 4, number of requesters (2..8).
- ANCHO, 16, operand/result width; must match the root core.
- ID_W, $clog2(N_SOL), width of the requester ID.
- LIMITE, 32, watchdog cycle limit (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sol_valido  in  N_SOL  per-requester request valid.
- sol_radicando  in  N_SOL*ANCHO  packed operands; requester i uses bits [i*ANCHO +: ANCHO].
- sol_listo  out  N_SOL  per-requester accept; one-hot or zero.
- resp_valido  out  1  one-cycle response strobe.
- resp_id  out  ID_W  ID of the requester owning the response.
- resp_raiz  out  ANCHO  square-root result.
- resp_error  out  1  watchdog abort flag; constant 0 without the feature.
- ocupado  out  1  high in any state other than LIBRE.
- raiz_iniciar  out  1  start pulse to the core.
- raiz_radicando  out  ANCHO  operand to the core, held stable from LANZAR through ESPERA.
- raiz_res_in  in  ANCHO  core result.
- raiz_terminado  in  1  core done flag; the core keeps it high until its next start.

Behaviour:
- Reset (rst=1 at a clock edge): state=LIBRE; all outputs 0; captured operand/ID cleared; round-robin pointer ptr=N_SOL-1, so requester 0 wins first. Reset mid-operation abandons the transaction with no response; the core shares the same reset.
- FSM states: LIBRE, LANZAR, ESPERA, ENTREGA.
- LIBRE:
  - Winner = first i with sol_valido[i]=1, searching ptr+1, ptr+2, ... modulo N_SOL.
  - sol_listo[winner] is driven combinationally in the same cycle. Transfer = sol_valido[i] & sol_listo[i] at the clock edge.
  - On transfer: latch operand into raiz_radicando, latch ID, set ptr=winner, go to LANZAR.
  - No valid requests: stay in LIBRE.
- LANZAR: raiz_iniciar=1 for exactly this one cycle; go to ESPERA. raiz_terminado is ignored in this cycle because it may still be high from the previous operation.
- ESPERA: raiz_iniciar=0. When raiz_terminado=1, register resp_raiz<=raiz_res_in and resp_id<=latched ID, then go to ENTREGA.
- ENTREGA: resp_valido=1 for one cycle; go to LIBRE. Responses have no backpressure; each requester filters on resp_id.
- Output timing: resp_id and resp_raiz hold their value until the next response. resp_valido and raiz_iniciar are registered. sol_listo is combinational and only ever set in LIBRE.
- Throughput: next grant no earlier than the cycle after ENTREGA, i.e. at most one outstanding operation.
- Latency: grant edge to resp_valido = 1 (LANZAR) + core latency + 1 (capture) cycles.
- Fairness: a requester that holds valid is served within N_SOL transactions. Requester i is never granted twice in a row while another requester is valid.
- Requester rules:
  - Holds valid and operand stable until sol_listo.
  - Dropping valid before grant is legal; the request is simply skipped.
  - May raise a new request in the cycle after its own resp_valido.
- Width: operands pass through unmodified. Radicando 0 is legal and returns 0.

Optional Feature:
- Macro: ARBITRO_RAIZ_TIMEOUT_EN.
- Defined:
  - A counter clears on entering ESPERA and increments each ESPERA cycle.
  - If it reaches LIMITE without raiz_terminado, go to ENTREGA with resp_raiz=0 and resp_error=1 (one-cycle pulse coincident with resp_valido).
  - The pointer still advances normally.
- Undefined: no counter logic; resp_error tied to 0; ESPERA waits indefinitely.

Test Plan:
- Single request: reset, sol_valido[0]=1, operand 144 -> sol_listo[0] pulses once; raiz_iniciar pulses once; later resp_valido=1, resp_id=0, resp_raiz=12.
- Boundaries: requester 2 with operands 0, 1, 65535 in turn -> resp_raiz 0, 1, 255; resp_id=2 each time.
- Simultaneous requests: all four valid from reset, operands 16/25/36/49 -> grant order 0,1,2,3; responses 4,5,6,7 with IDs 0..3; exactly one sol_listo bit per grant.
- Fairness: requesters 1 and 3 held valid continuously -> grants alternate 1,3,1,3; never the same ID twice in a row.
- Reset mid-ESPERA: assert rst for one cycle during an operation on 400 -> no resp_valido for that operation; ocupado=0 after reset; the next request on requester 0 returns the correct root.
- With ARBITRO_RAIZ_TIMEOUT_EN, LIMITE=32, raiz_terminado stubbed to 0 -> resp_valido with resp_error=1 and resp_raiz=0 exactly 32 ESPERA cycles after entry; the arbiter then grants the next requester.
